// File: rtl/rc_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : rc_pwm_multi
// Brief    : N-channel RC servo/ESC pulse generator with per-frame slew limit
//            and a command-timeout failsafe that returns channels to neutral.
// Revision : 1.0 - initial release
// ============================================================================
module rc_pwm_multi #(
    parameter int NUM_CH          = 2,
    parameter int CH_W            = 1,
    parameter int POS_W           = 8,
    parameter int CLK_DIV         = 1953,
    parameter int STEP_W          = 9,
    parameter int NEUTRAL         = 75,
    parameter int MIN_POS         = 50,
    parameter int MAX_POS         = 100,
    parameter int SLEW_STEP       = 0,
    parameter int FAILSAFE_FRAMES = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [POS_W-1:0]  cmd_pos,
    output logic              cmd_ready,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_start,
    output logic              failsafe
);

    localparam int c_tick_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_idle_w = (FAILSAFE_FRAMES > 0) ? $clog2(FAILSAFE_FRAMES + 1) : 1;
    localparam int c_cmp_w  = (STEP_W > POS_W) ? STEP_W : POS_W;
    localparam int c_slw_w  = POS_W + 1;

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(CLK_DIV - 1);
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(FAILSAFE_FRAMES - 1);
    localparam logic [c_idle_w-1:0] c_idle_max  = c_idle_w'(FAILSAFE_FRAMES);
    localparam logic [POS_W-1:0]    c_neutral   = POS_W'(NEUTRAL);
    localparam logic [POS_W-1:0]    c_min_pos   = POS_W'(MIN_POS);
    localparam logic [POS_W-1:0]    c_max_pos   = POS_W'(MAX_POS);
    localparam logic [c_slw_w-1:0]  c_step      = c_slw_w'(SLEW_STEP);

    logic [c_tick_w-1:0] r_tick_cnt;
    logic [STEP_W-1:0]   r_step;
    logic                r_ready;
    logic                r_frame_start;
    logic                r_failsafe;
    logic [c_idle_w-1:0] r_idle;
    logic [NUM_CH-1:0]   r_pwm;

    logic                w_tick;
    logic                w_fb;
    logic                w_accept;
    logic                w_trip;
    logic [POS_W-1:0]    w_cmd_pos;
    logic [NUM_CH-1:0]   w_pwm_next;

    assign w_tick   = (r_tick_cnt == c_tick_last);
    assign w_fb     = w_tick && (r_step == '1);
    assign w_accept = cmd_valid && r_ready;
    // An accepted command always wins over a failsafe trip on the same edge.
    assign w_trip   = (FAILSAFE_FRAMES != 0) && w_fb && !w_accept && (r_idle == c_idle_last);

    assign w_cmd_pos = (cmd_pos < c_min_pos) ? c_min_pos :
                       (cmd_pos > c_max_pos) ? c_max_pos : cmd_pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick_cnt    <= '0;
            r_step        <= '0;
            r_ready       <= 1'b0;
            r_frame_start <= 1'b0;
            r_pwm         <= '0;
        end else begin
            r_tick_cnt    <= w_tick ? '0 : r_tick_cnt + c_tick_w'(1);
            if (w_tick) begin
                r_step <= r_step + STEP_W'(1);
            end
            r_ready       <= 1'b1;
            r_frame_start <= w_fb;
            r_pwm         <= w_pwm_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle     <= '0;
            r_failsafe <= 1'b0;
        end else if (w_accept) begin
            r_idle     <= '0;
            r_failsafe <= 1'b0;
        end else if (w_fb && (FAILSAFE_FRAMES != 0) && (r_idle != c_idle_max)) begin
            r_idle <= r_idle + c_idle_w'(1);
            if (w_trip) begin
                r_failsafe <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [POS_W-1:0]   r_target;
        logic [POS_W-1:0]   r_active;
        logic [POS_W-1:0]   w_slew;
        logic [c_slw_w-1:0] w_tgt_x;
        logic [c_slw_w-1:0] w_act_x;

        always_comb begin
            w_tgt_x = {1'b0, r_target};
            w_act_x = {1'b0, r_active};
            w_slew  = r_target;
            if (SLEW_STEP != 0) begin
                if (w_tgt_x > w_act_x) begin
                    if ((w_tgt_x - w_act_x) > c_step) begin
                        w_slew = POS_W'(w_act_x + c_step);
                    end
                end else if ((w_act_x - w_tgt_x) > c_step) begin
                    w_slew = POS_W'(w_act_x - c_step);
                end
            end
        end

        // Active only moves on a frame boundary, so a pulse in flight is never altered.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_target <= c_neutral;
                r_active <= c_neutral;
            end else begin
                if (w_trip) begin
                    r_target <= c_neutral;
                end else if (w_accept && (cmd_ch == CH_W'(gi))) begin
                    r_target <= w_cmd_pos;
                end
                if (w_fb) begin
                    r_active <= w_slew;
                end
            end
        end

        assign w_pwm_next[gi] = (c_cmp_w'(r_step) < c_cmp_w'(r_active));
    end : g_ch

    assign cmd_ready   = r_ready;
    assign pwm_out     = r_pwm;
    assign frame_start = r_frame_start;
    assign failsafe    = r_failsafe;

endmodule
`default_nettype wire

// File: tb/tb_rc_pwm_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_rc_pwm_multi
// Brief    : Directed self-checking bench; dut_a runs without slew, dut_b with
//            a slew step of 2. High times are measured per frame in clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rc_pwm_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_a = 1'b0, valid_b = 1'b0;
    logic [1:0] ch_a = '0, ch_b = '0;
    logic [7:0] pos_a = '0, pos_b = '0;
    logic       ready_a, ready_b, fstart_a, fstart_b, fs_a, fs_b;
    logic [2:0] pwm_a, pwm_b;

    int n_checks = 0;
    int n_errors = 0;
    int meas_a[3], meas_b[3], acc_a[3], acc_b[3];
    int period_a = 0, cyc_a = 0;

    always #5 clk = ~clk;

    rc_pwm_multi #(
        .NUM_CH(3), .CH_W(2), .POS_W(8), .CLK_DIV(4), .STEP_W(5), .NEUTRAL(10),
        .MIN_POS(5), .MAX_POS(20), .SLEW_STEP(0), .FAILSAFE_FRAMES(3)
    ) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(valid_a), .cmd_ch(ch_a), .cmd_pos(pos_a),
        .cmd_ready(ready_a), .pwm_out(pwm_a), .frame_start(fstart_a), .failsafe(fs_a)
    );

    rc_pwm_multi #(
        .NUM_CH(3), .CH_W(2), .POS_W(8), .CLK_DIV(4), .STEP_W(5), .NEUTRAL(10),
        .MIN_POS(5), .MAX_POS(20), .SLEW_STEP(2), .FAILSAFE_FRAMES(3)
    ) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(valid_b), .cmd_ch(ch_b), .cmd_pos(pos_b),
        .cmd_ready(ready_b), .pwm_out(pwm_b), .frame_start(fstart_b), .failsafe(fs_b)
    );

    // Per-frame high-time and frame-period measurement, latched at frame_start.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                acc_a[i] <= 0;
                acc_b[i] <= 0;
            end
            cyc_a <= 0;
        end else if (fstart_a) begin
            for (int i = 0; i < 3; i++) begin
                meas_a[i] <= acc_a[i];
                meas_b[i] <= acc_b[i];
                acc_a[i]  <= int'(pwm_a[i]);
                acc_b[i]  <= int'(pwm_b[i]);
            end
            period_a <= cyc_a;
            cyc_a    <= 1;
        end else begin
            for (int i = 0; i < 3; i++) begin
                acc_a[i] <= acc_a[i] + int'(pwm_a[i]);
                acc_b[i] <= acc_b[i] + int'(pwm_b[i]);
            end
            cyc_a <= cyc_a + 1;
        end
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!fstart_a && n < 400);
        if (!fstart_a) begin
            n_checks++;
            n_errors++;
            $display("FAIL frame_timeout: frame_start not seen within %0d cycles", n);
        end
        @(negedge clk); #1;
    endtask

    task automatic send_a(input logic [1:0] ch, input logic [7:0] pos);
        valid_a = 1'b1; ch_a = ch; pos_a = pos;
        @(posedge clk); #1;
        valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] ch, input logic [7:0] pos);
        valid_b = 1'b1; ch_b = ch; pos_b = pos;
        @(posedge clk); #1;
        valid_b = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (pwm_a !== 3'b000) begin n_errors++; $display("FAIL rst_pwm: got %b want 000", pwm_a); end
        n_checks++; if (ready_a !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %b want 0", ready_a); end
        n_checks++; if (fstart_a !== 1'b0) begin n_errors++; $display("FAIL rst_fstart: got %b want 0", fstart_a); end
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL rst_failsafe: got %b want 0", fs_a); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (ready_a !== 1'b1) begin n_errors++; $display("FAIL rel_ready: got %b want 1", ready_a); end
        wait_frame();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (meas_a[i] !== 40) begin n_errors++; $display("FAIL neutral_ch%0d: high %0d clk want 40", i, meas_a[i]); end
        end
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL fs_frame1: got %b want 0", fs_a); end
        wait_frame();
        n_checks++; if (period_a !== 128) begin n_errors++; $display("FAIL frame_period: got %0d want 128", period_a); end
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL fs_frame2: got %b want 0", fs_a); end
        wait_frame();
        n_checks++; if (fs_a !== 1'b1) begin n_errors++; $display("FAIL fs_frame3: got %b want 1", fs_a); end
    endtask

    task automatic test_cmd_jump();
        int exp4[3] = '{40, 40, 40};
        int exp5[3] = '{40, 60, 40};
        repeat (20) @(posedge clk);
        #1;
        send_a(2'd1, 8'd15);
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL jump_fs_clear: got %b want 0", fs_a); end
        wait_frame();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (meas_a[i] !== exp4[i]) begin n_errors++; $display("FAIL jump_cur_ch%0d: high %0d want %0d", i, meas_a[i], exp4[i]); end
        end
        wait_frame();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (meas_a[i] !== exp5[i]) begin n_errors++; $display("FAIL jump_next_ch%0d: high %0d want %0d", i, meas_a[i], exp5[i]); end
        end
    endtask

    task automatic test_clamp();
        int exp_out[3] = '{80, 60, 40};
        repeat (20) @(posedge clk);
        #1;
        send_a(2'd0, 8'd2);
        wait_frame();
        repeat (20) @(posedge clk);
        #1;
        send_a(2'd0, 8'd200);
        wait_frame();
        n_checks++; if (meas_a[0] !== 20) begin n_errors++; $display("FAIL clamp_low: high %0d want 20", meas_a[0]); end
        wait_frame();
        n_checks++; if (meas_a[0] !== 80) begin n_errors++; $display("FAIL clamp_high: high %0d want 80", meas_a[0]); end
        repeat (20) @(posedge clk);
        #1;
        send_a(2'd3, 8'd7);
        wait_frame();
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL oor_idle_clear: fs %b want 0", fs_a); end
        wait_frame();
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL oor_idle_clear2: fs %b want 0", fs_a); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (meas_a[i] !== exp_out[i]) begin n_errors++; $display("FAIL oor_ch%0d: high %0d want %0d", i, meas_a[i], exp_out[i]); end
        end
    endtask

    task automatic test_failsafe();
        int exp_hold[3] = '{80, 60, 40};
        repeat (20) @(posedge clk);
        #1;
        send_a(2'd0, 8'd20);
        wait_frame();
        wait_frame();
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL fs_early: got %b want 0", fs_a); end
        wait_frame();
        n_checks++; if (fs_a !== 1'b1) begin n_errors++; $display("FAIL fs_trip: got %b want 1", fs_a); end
        wait_frame();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (meas_a[i] !== exp_hold[i]) begin n_errors++; $display("FAIL fs_hold_ch%0d: high %0d want %0d", i, meas_a[i], exp_hold[i]); end
        end
        wait_frame();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (meas_a[i] !== 40) begin n_errors++; $display("FAIL fs_neutral_ch%0d: high %0d want 40", i, meas_a[i]); end
        end
        repeat (20) @(posedge clk);
        #1;
        send_a(2'd0, 8'd6);
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL fs_release: got %b want 0", fs_a); end
        wait_frame();
        wait_frame();
        n_checks++; if (meas_a[0] !== 24) begin n_errors++; $display("FAIL fs_recmd: high %0d want 24", meas_a[0]); end
        n_checks++; if (meas_a[1] !== 40) begin n_errors++; $display("FAIL fs_other_ch1: high %0d want 40", meas_a[1]); end
    endtask

    task automatic test_slew();
        int exp_up[5] = '{48, 56, 64, 72, 76};
        repeat (20) @(posedge clk);
        #1;
        send_b(2'd2, 8'd19);
        n_checks++; if (fs_b !== 1'b0) begin n_errors++; $display("FAIL slew_fs_clear: got %b want 0", fs_b); end
        wait_frame();
        for (int k = 0; k < 5; k++) begin
            repeat (20) @(posedge clk);
            #1;
            send_b(2'd2, 8'd19);
            wait_frame();
            n_checks++;
            if (meas_b[2] !== exp_up[k]) begin n_errors++; $display("FAIL slew_up_%0d: high %0d want %0d", k, meas_b[2], exp_up[k]); end
        end
        n_checks++; if (meas_b[0] !== 40 || meas_b[1] !== 40) begin n_errors++; $display("FAIL slew_others: ch0 %0d ch1 %0d want 40 40", meas_b[0], meas_b[1]); end
        repeat (20) @(posedge clk);
        #1;
        send_b(2'd2, 8'd5);
        wait_frame();
        wait_frame();
        n_checks++; if (meas_b[2] !== 68) begin n_errors++; $display("FAIL slew_down: high %0d want 68", meas_b[2]); end
    endtask

    task automatic test_back_to_back();
        // Command landing exactly on the frame-boundary cycle.
        repeat (127) @(posedge clk);
        #1;
        send_a(2'd1, 8'd18);
        n_checks++; if (fstart_a !== 1'b1) begin n_errors++; $display("FAIL fb_align: fstart %b want 1", fstart_a); end
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL fb_fs_clear: got %b want 0", fs_a); end
        wait_frame();
        n_checks++; if (meas_a[1] !== 40) begin n_errors++; $display("FAIL fb_delay: high %0d want 40", meas_a[1]); end
        wait_frame();
        n_checks++; if (meas_a[1] !== 72) begin n_errors++; $display("FAIL fb_apply: high %0d want 72", meas_a[1]); end
        repeat (127) @(posedge clk);
        #1;
        send_a(2'd1, 8'd18);
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL cmd_beats_trip: fs %b want 0", fs_a); end
    endtask

    task automatic test_reset_midframe();
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (pwm_a !== 3'b111) begin n_errors++; $display("FAIL pre_rst_pwm: got %b want 111", pwm_a); end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (pwm_a !== 3'b000 || pwm_b !== 3'b000) begin n_errors++; $display("FAIL midrst_pwm: a %b b %b want 000", pwm_a, pwm_b); end
        n_checks++; if (ready_a !== 1'b0) begin n_errors++; $display("FAIL midrst_ready: got %b want 0", ready_a); end
        n_checks++; if (fstart_a !== 1'b0) begin n_errors++; $display("FAIL midrst_fstart: got %b want 0", fstart_a); end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (ready_a !== 1'b0) begin n_errors++; $display("FAIL midrst_ready_hold: got %b want 0", ready_a); end
        @(posedge clk); #1;
        n_checks++; if (ready_a !== 1'b1) begin n_errors++; $display("FAIL midrst_ready_rel: got %b want 1", ready_a); end
        wait_frame();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (meas_a[i] !== 40) begin n_errors++; $display("FAIL post_rst_ch%0d: high %0d want 40", i, meas_a[i]); end
        end
        n_checks++; if (fs_a !== 1'b0) begin n_errors++; $display("FAIL post_rst_fs: got %b want 0", fs_a); end
    endtask

    initial begin
        test_reset();
        test_cmd_jump();
        test_clamp();
        test_failsafe();
        test_slew();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
